// File: rtl/elastic_pipe_reg_pkg.sv
// Shared helpers for the elastic pipeline stage and its pointer sub-module.
package elastic_pipe_reg_pkg;

    // A DEPTH=1 buffer still needs a 1-bit pointer so the port is never zero-width.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/elastic_pipe_ptr.sv
// Wrapping index 0..DEPTH-1 with synchronous clear; wrap is an explicit compare, not a modulo.
module elastic_pipe_ptr
    import elastic_pipe_reg_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [PTR_W-1:0] o_ptr
);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (i_clr) begin
            w_ptr_nxt = '0;
        end else if (i_inc) begin
            if (r_ptr == PTR_W'(DEPTH - 1)) begin
                w_ptr_nxt = '0;
            end else begin
                w_ptr_nxt = r_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic valid/ready pipeline stage: DEPTH-entry circular buffer with flush and clear value.
// Optional zero-latency pass-through when empty is enabled by ELASTIC_PIPE_BYPASS_EN.
module elastic_pipe_reg
    import elastic_pipe_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      DEPTH     = 2,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           out_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_rd_ptr;
    logic [PTR_W-1:0] w_wr_ptr;
    logic             w_push;
    logic             w_pop;
    logic             w_bypass;
    logic             w_store;
    logic             w_deq;

    // Registered-only ready: no combinational path from out_ready_i.
    assign in_ready_o = (r_count != CNT_W'(DEPTH));

`ifdef ELASTIC_PIPE_BYPASS_EN
    assign w_bypass = (r_count == '0) & in_valid_i & ~flush_i & reset_n;
`else
    assign w_bypass = 1'b0;
`endif

    assign out_valid_o = (r_count != '0) | w_bypass;

    always_comb begin
        out_data_o = CLR_VALUE;
        if (r_count != '0) begin
            out_data_o = r_mem[w_rd_ptr];
        end else if (w_bypass) begin
            out_data_o = in_data_i;
        end
    end

    assign w_push = in_valid_i & in_ready_o;
    assign w_pop  = out_valid_o & out_ready_i;
    // A bypassed item that is consumed immediately never touches storage.
    assign w_store = w_push & ~(w_bypass & out_ready_i);
    assign w_deq   = w_pop & ~w_bypass;

    elastic_pipe_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (flush_i),
        .i_inc   (w_deq),
        .o_ptr   (w_rd_ptr)
    );

    elastic_pipe_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (flush_i),
        .i_inc   (w_store),
        .o_ptr   (w_wr_ptr)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (flush_i) begin
            r_count <= '0;
        end else if (w_store && !w_deq) begin
            r_count <= r_count + 1'b1;
        end else if (w_deq && !w_store) begin
            r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && !flush_i && w_store) begin
            r_mem[w_wr_ptr] <= in_data_i;
        end
    end

    assign count_o = r_count;

    // Stored head must not change until it is popped.
    a_out_stable : assert property (@(posedge clk) disable iff (!reset_n)
        (r_count != '0 && !w_pop && !flush_i) |=> $stable(out_data_o));

    a_in_stable : assert property (@(posedge clk) disable iff (!reset_n)
        (in_valid_i && !in_ready_o && !flush_i) |=> (!in_valid_i || $stable(in_data_i)));

endmodule
